bcd_addsub_serial: RTL and testbench

Digit-serial, parametrised BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first. It is the multi-cycle successor to the ripple BCD adders in the arithmetic library. It trades latency for a single shared digit slice, and adds nines'-complement subtraction and a start/done handshake. It sits between a control FSM and BCD display or accumulator registers.

---
 rtl/bcd_addsub_serial.sv | 192 +++++++++++++++++++
 tb/tb_bcd_addsub_serial.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_addsub_serial.sv
// rtl/bcd_addsub_serial.sv - digit-serial BCD adder/subtractor, one digit per clock, LSD first
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           request, sampled only in IDLE; latches a, b, sub, cin
//   sub             0 = add, 1 = subtract (nines' complement of b, use cin=1 for A-B)
//   a, b            packed BCD operands, digit 0 in [3:0]
//   cin             carry into digit 0
//   busy            high while digits are being processed
//   done            one-cycle pulse when sum/cout/invalid update
//   sum, cout       packed BCD result and decimal carry out; held between completions
//   invalid         some operand digit was >9 (only when BCD_SERIAL_CHECK_EN is defined)
//
// Optional feature macro: BCD_SERIAL_CHECK_EN (digit range check; otherwise invalid = 0)

module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            sub_q, sub_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            done_q, done_d;

    // Digit slice: the current digit is always at the bottom of the operand shifters.
    logic [3:0]      a_i, b_i, b_eff, digit;
    logic [4:0]      raw, adj;
    logic            carry_next;
    logic [W-1:0]    a_shift, b_shift, res_shift;

    always_comb begin
        a_i   = a_q[3:0];
        b_i   = b_q[3:0];
        b_eff = sub_q ? (4'd9 - b_i) : b_i;
        raw   = {1'b0, a_i} + {1'b0, b_eff} + {4'd0, carry_q};
        adj   = raw + 5'd6;
        if (raw > 5'd9) begin
            digit      = adj[3:0];
            carry_next = 1'b1;
        end else begin
            digit      = raw[3:0];
            carry_next = 1'b0;
        end
        // Operands shift right by a digit; the result enters at the top so that
        // after DIGITS steps digit 0 has reached [3:0].
        a_shift   = '0;
        b_shift   = '0;
        res_shift = '0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            a_shift[4*i +: 4]   = a_q[4*(i+1) +: 4];
            b_shift[4*i +: 4]   = b_q[4*(i+1) +: 4];
            res_shift[4*i +: 4] = res_q[4*(i+1) +: 4];
        end
        res_shift[W-1 -: 4] = digit;
    end

`ifdef BCD_SERIAL_CHECK_EN
    logic flag_q, flag_d;
    logic invalid_q, invalid_d;
    logic digit_bad;

    always_comb begin
        digit_bad = (a_i > 4'd9) || (b_i > 4'd9);
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
`ifdef BCD_SERIAL_CHECK_EN
        flag_d    = flag_q;
        invalid_d = invalid_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef BCD_SERIAL_CHECK_EN
                    flag_d  = 1'b0;
`endif
                end
            end
            RUN: begin
                a_d     = a_shift;
                b_d     = b_shift;
                res_d   = res_shift;
                carry_d = carry_next;
                idx_d   = idx_q + 1'b1;
`ifdef BCD_SERIAL_CHECK_EN
                flag_d  = flag_q | digit_bad;
`endif
                if (idx_q == LAST) begin
                    sum_d   = res_shift;
                    cout_d  = carry_next;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
`ifdef BCD_SERIAL_CHECK_EN
                    invalid_d = flag_q | digit_bad;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

`ifdef BCD_SERIAL_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            flag_q    <= flag_d;
            invalid_q <= invalid_d;
        end
    end

    assign invalid = invalid_q;
`else
    assign invalid = 1'b0;
`endif

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// tb/tb_bcd_addsub_serial.sv - scoreboard bench for bcd_addsub_serial (DIGITS=4)

module tb_bcd_addsub_serial;

    localparam int D = 4;
`ifdef BCD_SERIAL_CHECK_EN
    localparam logic EXP_INV = 1'b1;
`else
    localparam logic EXP_INV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, sub, cin;
    logic [15:0] a, b;
    logic        busy, done, cout, invalid;
    logic [15:0] sum;

    always #5 clk = ~clk;

    bcd_addsub_serial #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        inv;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal reference: A + (sub ? 9999-B : B) + cin, split at 10^4.
    task automatic push_model(input logic [15:0] ia, ib, input logic is, ic);
        exp_t e;
        int r;
        r = bcd2int(ia) + (is ? (9999 - bcd2int(ib)) : bcd2int(ib)) + int'(ic);
        e.s   = int2bcd(r % 10000);
        e.c   = (r >= 10000);
        e.inv = 1'b0;
        q.push_back(e);
    endtask

    // Called at a negedge; start is seen at the following posedge (accept edge).
    task automatic drive(input logic [15:0] ia, ib, input logic is, ic);
        a = ia; b = ib; sub = is; cin = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; sub = $urandom; cin = $urandom;
    endtask

    // n0 = negedges elapsed since the accept edge. lat = edges after accept until done visible.
    task automatic wait_done(input int n0, output int lat, output int busy_n,
                             output bit moved, output bit tmo);
        int n = n0;
        logic [15:0] s0 = sum;
        busy_n = 0;
        moved  = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_n++;
            if (sum !== s0) moved = 1;
            @(negedge clk);
            n++;
        end
        tmo = (done !== 1'b1);
        lat = n - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; sub = 0; cin = 0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (sum !== 16'h0) begin bad++; $display("FAIL reset_sum got=%h want=0000", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
        total++; if (invalid !== 1'b0) begin bad++; $display("FAIL reset_invalid got=%b want=0", invalid); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith();
        logic [15:0] ta [0:9];
        logic [15:0] tb_ [0:9];
        logic        ts [0:9];
        logic        tc [0:9];
        int lat, bn; bit mv, tmo;
        exp_t e;
        ta[0] = 16'h1234; tb_[0] = 16'h5678; ts[0] = 0; tc[0] = 0;
        ta[1] = 16'h9999; tb_[1] = 16'h0001; ts[1] = 0; tc[1] = 0;
        ta[2] = 16'h0000; tb_[2] = 16'h0000; ts[2] = 0; tc[2] = 1;
        ta[3] = 16'h5000; tb_[3] = 16'h1234; ts[3] = 1; tc[3] = 1;
        ta[4] = 16'h1234; tb_[4] = 16'h5000; ts[4] = 1; tc[4] = 1;
        ta[5] = 16'h9999; tb_[5] = 16'h9999; ts[5] = 0; tc[5] = 1;
        for (int k = 6; k < 10; k++) begin
            ta[k]  = int2bcd(int'($urandom_range(0, 9999)));
            tb_[k] = int2bcd(int'($urandom_range(0, 9999)));
            ts[k]  = 1'($urandom);
            tc[k]  = 1'($urandom);
        end
        for (int k = 0; k < 10; k++) begin
            push_model(ta[k], tb_[k], ts[k], tc[k]);
            drive(ta[k], tb_[k], ts[k], tc[k]);
            wait_done(1, lat, bn, mv, tmo);
            total++;
            if (tmo) begin
                bad++; $display("FAIL arith%0d_timeout got=no_done want=done", k);
                void'(q.pop_front());
            end else begin
                e = q.pop_front();
                total++; if (sum !== e.s) begin bad++; $display("FAIL arith%0d_sum got=%h want=%h", k, sum, e.s); end
                total++; if (cout !== e.c) begin bad++; $display("FAIL arith%0d_cout got=%b want=%b", k, cout, e.c); end
                total++; if (invalid !== e.inv) begin bad++; $display("FAIL arith%0d_invalid got=%b want=%b", k, invalid, e.inv); end
                total++; if (lat !== D) begin bad++; $display("FAIL arith%0d_latency got=%0d want=%0d", k, lat, D); end
                total++; if (bn !== D) begin bad++; $display("FAIL arith%0d_busy_cycles got=%0d want=%0d", k, bn, D); end
                total++; if (mv) begin bad++; $display("FAIL arith%0d_sum_stable got=changed want=held", k); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL arith%0d_busy_at_done got=%b want=0", k, busy); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_handshake();
        int lat, bn, dn; bit mv, tmo;
        exp_t e;
        // start pulsed during RUN with different operands: ignored
        push_model(16'h0042, 16'h0058, 0, 0);
        drive(16'h0042, 16'h0058, 0, 0);
        @(negedge clk);
        a = 16'h9999; b = 16'h9999; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat, bn, mv, tmo);
        e = q.pop_front();
        total++; if (tmo || sum !== e.s) begin bad++; $display("FAIL hs_ignore_sum got=%h want=%h", sum, e.s); end
        total++; if (lat !== D) begin bad++; $display("FAIL hs_ignore_latency got=%0d want=%0d", lat, D); end
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL hs_single_done got=%0d want=0", dn); end
        // back-to-back: second start in the done cycle
        push_model(16'h0777, 16'h0333, 0, 0);
        drive(16'h0777, 16'h0333, 0, 0);
        wait_done(1, lat, bn, mv, tmo);
        e = q.pop_front();
        total++; if (tmo || sum !== e.s) begin bad++; $display("FAIL hs_first_sum got=%h want=%h", sum, e.s); end
        push_model(16'h8000, 16'h0999, 1, 1);
        drive(16'h8000, 16'h0999, 1, 1);
        wait_done(1, lat, bn, mv, tmo);
        e = q.pop_front();
        total++; if (tmo || sum !== e.s) begin bad++; $display("FAIL hs_b2b_sum got=%h want=%h", sum, e.s); end
        total++; if (cout !== e.c) begin bad++; $display("FAIL hs_b2b_cout got=%b want=%b", cout, e.c); end
        total++; if (lat !== D) begin bad++; $display("FAIL hs_b2b_latency got=%0d want=%0d", lat, D); end
        total++; if (mv) begin bad++; $display("FAIL hs_b2b_sum_hold got=changed want=held"); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, bn, dn; bit mv, tmo;
        exp_t e;
        push_model(16'h4321, 16'h1111, 0, 0);
        drive(16'h4321, 16'h1111, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got=%b%b want=00", busy, done); end
        total++; if (sum !== 16'h0 || cout !== 1'b0 || invalid !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs got=%h/%b/%b want=0000/0/0", sum, cout, invalid);
        end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", dn); end
        push_model(16'h0001, 16'h0001, 0, 0);
        drive(16'h0001, 16'h0001, 0, 0);
        wait_done(1, lat, bn, mv, tmo);
        e = q.pop_front();
        total++; if (tmo || sum !== 16'h0002 || sum !== e.s) begin bad++; $display("FAIL rstmid_after_sum got=%h want=0002", sum); end
        @(negedge clk);
    endtask

    task automatic test_invalid();
        int lat, bn; bit mv, tmo;
        exp_t e;
        e.s = 16'h0100; e.c = 1'b0; e.inv = EXP_INV;
        q.push_back(e);
        drive(16'h00A0, 16'h0000, 0, 0);
        wait_done(1, lat, bn, mv, tmo);
        e = q.pop_front();
        total++; if (tmo || sum !== e.s) begin bad++; $display("FAIL invalid_sum got=%h want=%h", sum, e.s); end
        total++; if (invalid !== e.inv) begin bad++; $display("FAIL invalid_flag got=%b want=%b", invalid, e.inv); end
        total++; if (cout !== e.c) begin bad++; $display("FAIL invalid_cout got=%b want=%b", cout, e.c); end
        // a clean follow-up operation clears the flag
        push_model(16'h0005, 16'h0005, 0, 0);
        drive(16'h0005, 16'h0005, 0, 0);
        wait_done(1, lat, bn, mv, tmo);
        total++; if (tmo || invalid !== 1'b0) begin bad++; $display("FAIL invalid_clear got=%b want=0", invalid); end
        e = q.pop_front();
        total++; if (sum !== e.s) begin bad++; $display("FAIL invalid_clear_sum got=%h want=%h", sum, e.s); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_handshake();
        test_reset_mid();
        test_invalid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
